// File: rtl/mdu.sv
// Multiply/divide unit: multi-cycle HI/LO producer with a busy counter for the stall unit.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu accumulate ops.
module mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hilo_sel,
   output logic        busy,
   output logic [31:0] out,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } op_e;

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

   op_e               op_c;
   logic              is_mul;
   logic              is_div;
   logic [CNT_W-1:0]  cnt;
   logic [63:0]       tmp;
   logic [63:0]       res;

   logic signed [63:0] sprod;
   logic        [63:0] uprod;
   logic signed [31:0] sa;
   logic signed [31:0] sb;
   logic signed [31:0] squot;
   logic signed [31:0] srem;
   logic        [31:0] uquot;
   logic        [31:0] urem;

   assign op_c = op_e'(op);

   assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign uprod = {32'd0, A} * {32'd0, B};

   // Divisor forced to 1 when zero so the datapath never divides by zero; that result is muxed away.
   assign sa    = $signed(A);
   assign sb    = (B == '0) ? 32'sd1 : $signed(B);
   assign squot = sa / sb;
   assign srem  = sa % sb;
   assign uquot = A / ((B == '0) ? 32'd1 : B);
   assign urem  = A % ((B == '0) ? 32'd1 : B);

   always_comb begin
      is_mul = 1'b0;
      is_div = 1'b0;
      res    = '0;
      case (op_c)
         OP_MULT:  begin is_mul = 1'b1; res = sprod; end
         OP_MULTU: begin is_mul = 1'b1; res = uprod; end
         // Divide by zero re-captures the current HI/LO, so completion leaves them unchanged.
         OP_DIV:   begin is_div = 1'b1; res = (B == '0) ? {HI, LO} : {srem, squot}; end
         OP_DIVU:  begin is_div = 1'b1; res = (B == '0) ? {HI, LO} : {urem, uquot}; end
`ifdef MDU_MADD_EN
         OP_MADD:  begin is_mul = 1'b1; res = {HI, LO} + sprod; end
         OP_MADDU: begin is_mul = 1'b1; res = {HI, LO} + uprod; end
         OP_MSUB:  begin is_mul = 1'b1; res = {HI, LO} - sprod; end
         OP_MSUBU: begin is_mul = 1'b1; res = {HI, LO} - uprod; end
`endif
         default: ;
      endcase
   end

   assign busy = is_mul | is_div | (cnt != '0);
   assign out  = hilo_sel ? HI : LO;

   always_ff @(posedge clk) begin
      if (reset) begin
         HI  <= '0;
         LO  <= '0;
         cnt <= '0;
         tmp <= '0;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            HI <= tmp[63:32];
            LO <= tmp[31:0];
         end
      end else if (is_mul || is_div) begin
         cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         tmp <= res;
      end else if (op_c == OP_MTHI) begin
         HI <= A;
      end else if (op_c == OP_MTLO) begin
         LO <= A;
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results, busy timing, ignore, reset abort.
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        hilo_sel;
   logic        busy;
   logic [31:0] out;
   logic [31:0] HI;
   logic [31:0] LO;

   int unsigned checks = 0;
   int unsigned fails  = 0;
   logic [31:0] exp_hi;
   logic [31:0] exp_lo;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .op(op), .A(A), .B(B), .hilo_sel(hilo_sel),
      .busy(busy), .out(out), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   // Advance one edge; inputs return to idle shortly after it.
   task automatic tick();
      @(posedge clk);
      #1;
      op = 4'd0;
      #1;
   endtask

   // Issue an md-op, expect busy for n cycles (issue cycle included) with old HI/LO visible, then the new values.
   task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned n, input logic [31:0] hi_e, input logic [31:0] lo_e);
      op = o; A = a; B = b;
      #1;
      for (int unsigned i = 0; i < n; i++) begin
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_hold_hi"}, HI, exp_hi);
         check({tag, "_hold_lo"}, LO, exp_lo);
         tick();
      end
      exp_hi = hi_e;
      exp_lo = lo_e;
      check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, HI, exp_hi);
      check({tag, "_lo"}, LO, exp_lo);
   endtask

   task automatic mt(input string tag, input logic [3:0] o, input logic [31:0] a);
      op = o; A = a;
      #1;
      check({tag, "_issue_busy"}, {31'd0, busy}, 32'd0);
      tick();
      if (o == 4'd5) exp_hi = a; else exp_lo = a;
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, HI, exp_hi);
      check({tag, "_lo"}, LO, exp_lo);
   endtask

   initial begin
      reset = 1'b1; op = 4'd0; A = '0; B = '0; hilo_sel = 1'b0;
      exp_hi = '0; exp_lo = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_out", out, 32'd0);

      run_md("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 6, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      hilo_sel = 1'b1; #1;
      check("mult_out_hi", out, 32'hFFFF_FFFF);
      hilo_sel = 1'b0; #1;
      check("mult_out_lo", out, 32'hFFFF_FFFA);

      run_md("divu", 4'd4, 32'd7, 32'd2, 11, 32'd1, 32'd3);
      run_md("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6, 32'hFFFF_FFFE, 32'h0000_0001);

      mt("mthi", 4'd5, 32'h1234_5678);
      hilo_sel = 1'b1; #1;
      check("mthi_out", out, 32'h1234_5678);
      hilo_sel = 1'b0;

      mt("mthi_aa", 4'd5, 32'h0000_00AA);
      mt("mtlo_aa", 4'd6, 32'h0000_00AA);
      run_md("div0", 4'd3, 32'd5, 32'd0, 11, 32'h0000_00AA, 32'h0000_00AA);

      // Ops presented while the counter runs are ignored.
      op = 4'd1; A = 32'd2; B = 32'd3; #1;
      tick(); tick(); tick();
      op = 4'd1; A = 32'd7; B = 32'd7; #1;
      check("ign_busy", {31'd0, busy}, 32'd1);
      tick();
      op = 4'd5; A = 32'hDEAD_BEEF; #1;
      tick(); tick();
      check("ign_busy_end", {31'd0, busy}, 32'd0);
      check("ign_hi", HI, 32'd0);
      check("ign_lo", LO, 32'd6);
      tick();
      check("ign_no_restart", {31'd0, busy}, 32'd0);
      exp_hi = 32'd0; exp_lo = 32'd6;

      // Reset at cnt==2 aborts the multiply.
      op = 4'd1; A = 32'd3; B = 32'd3; #1;
      tick(); tick(); tick(); tick();
      reset = 1'b1; #1;
      @(posedge clk); #1;
      reset = 1'b0; #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_hi", HI, 32'd0);
      check("abort_lo", LO, 32'd0);
      repeat (3) tick();
      check("abort_no_wb", LO, 32'd0);
      exp_hi = '0; exp_lo = '0;

      mt("mtlo_55", 4'd6, 32'h0000_0055);
      reset = 1'b1; op = 4'd6; A = 32'h0000_0077; #1;
      @(posedge clk); #1;
      reset = 1'b0; op = 4'd0; #1;
      check("rst_over_op_lo", LO, 32'd0);
      check("rst_over_op_busy", {31'd0, busy}, 32'd0);
      exp_lo = '0;

      op = 4'd12; A = 32'h0000_0099; B = 32'd1; #1;
      check("op12_busy", {31'd0, busy}, 32'd0);
      tick();
      check("op12_lo", LO, 32'd0);

      mt("mthi_0", 4'd5, 32'd0);
      mt("mtlo_ff", 4'd6, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
      run_md("maddu", 4'd8, 32'd1, 32'd1, 6, 32'd1, 32'd0);
      run_md("msub", 4'd9, 32'd1, 32'd1, 6, 32'd0, 32'hFFFF_FFFF);
`else
      op = 4'd8; A = 32'd1; B = 32'd1; #1;
      check("maddu_off_busy", {31'd0, busy}, 32'd0);
      tick();
      check("maddu_off_busy2", {31'd0, busy}, 32'd0);
      check("maddu_off_hi", HI, 32'd0);
      check("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
